// File: rtl/mc_control_fsm_pkg.sv
// rtl/mc_control_fsm_pkg.sv - shared encodings for the MIPS-Lite3 multicycle control unit
package mc_control_fsm_pkg;

   typedef enum logic [2:0] {
      STATE_FETCH     = 3'd0,
      STATE_DECODE    = 3'd1,
      STATE_EXECUTE   = 3'd2,
      STATE_MEMORY    = 3'd3,
      STATE_WRITEBACK = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FUNCT_ADDU = 6'b100001;
   localparam logic [5:0] FUNCT_SUBU = 6'b100011;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;
   localparam logic [5:0] FUNCT_JR   = 6'b001000;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_SLT = 3'b011;
   localparam logic [2:0] ALU_LUI = 3'b100;

   localparam logic [1:0] ALUA_PC = 2'b00;
   localparam logic [1:0] ALUA_A  = 2'b01;

   localparam logic [1:0] ALUB_B       = 2'b00;
   localparam logic [1:0] ALUB_FOUR    = 2'b01;
   localparam logic [1:0] ALUB_IMM     = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;

   localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
   localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
   localparam logic [1:0] MEMTOREG_LINK   = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REG    = 2'b11;

   localparam int NUM_CLS  = 11;
   localparam int CLS_ADDU = 0;
   localparam int CLS_SUBU = 1;
   localparam int CLS_SLT  = 2;
   localparam int CLS_JR   = 3;
   localparam int CLS_ORI  = 4;
   localparam int CLS_LUI  = 5;
   localparam int CLS_LW   = 6;
   localparam int CLS_SW   = 7;
   localparam int CLS_BEQ  = 8;
   localparam int CLS_J    = 9;
   localparam int CLS_JAL  = 10;

   typedef logic [NUM_CLS-1:0] instr_class_t;

   typedef struct packed {
      logic [2:0] alu_ctrl;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic [1:0] pc_src;
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       ext_op;
      logic       illegal_instr;
   } ctrl_t;

   function automatic logic [2:0] r_alu_ctrl(input instr_class_t cls);
      if (cls[CLS_SUBU]) return ALU_SUB;
      if (cls[CLS_SLT])  return ALU_SLT;
      return ALU_ADD;
   endfunction

endpackage

// File: rtl/mc_instr_decode.sv
// rtl/mc_instr_decode.sv - maps the instruction word to a one-hot class; an empty class is illegal
module mc_instr_decode
   import mc_control_fsm_pkg::*;
(
   input  logic [31:0]  instr,
   output instr_class_t cls,
   output logic         illegal
);

   logic [5:0] op;
   logic [5:0] funct;
   logic       unused_fields;

   assign op            = instr[31:26];
   assign funct         = instr[5:0];
   assign unused_fields = ^instr[25:6];

   always_comb begin
      cls = '0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FUNCT_ADDU: cls[CLS_ADDU] = 1'b1;
               FUNCT_SUBU: cls[CLS_SUBU] = 1'b1;
               FUNCT_SLT:  cls[CLS_SLT]  = 1'b1;
               FUNCT_JR:   cls[CLS_JR]   = 1'b1;
               default:    cls           = '0;
            endcase
         end
         OP_ORI:  cls[CLS_ORI] = 1'b1;
         OP_LUI:  cls[CLS_LUI] = 1'b1;
         OP_LW:   cls[CLS_LW]  = 1'b1;
         OP_SW:   cls[CLS_SW]  = 1'b1;
         OP_BEQ:  cls[CLS_BEQ] = 1'b1;
         OP_J:    cls[CLS_J]   = 1'b1;
         OP_JAL:  cls[CLS_JAL] = 1'b1;
         default: cls          = '0;
      endcase
   end

   assign illegal = (cls == '0);

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle control FSM: Moore control outputs, retire counter
module mc_control_fsm
   import mc_control_fsm_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             zero,
   output logic [2:0]       alu_ctrl,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic [1:0]       pc_src,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             ir_write,
   output logic             ext_op,
   output logic [2:0]       current_state,
   output logic             illegal_instr,
   output logic [CNT_W-1:0] instr_count
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             retire;
   instr_class_t     cls;
   logic             illegal;
   logic             is_r_arith;
   ctrl_t            ctrl_c, ctrl;
   logic             unused_zero;

   // Branch resolution happens in the PC write-enable logic, so zero never steers the FSM.
   assign unused_zero = zero;

   mc_instr_decode u_decode (
      .instr   (instr),
      .cls     (cls),
      .illegal (illegal)
   );

   assign is_r_arith = cls[CLS_ADDU] | cls[CLS_SUBU] | cls[CLS_SLT];

   always_comb begin
      ctrl_c  = '0;
      state_d = STATE_FETCH;
      retire  = 1'b0;
      case (state_q)
         STATE_FETCH: begin
            ctrl_c.ir_write  = 1'b1;
            ctrl_c.alu_src_a = ALUA_PC;
            ctrl_c.alu_src_b = ALUB_FOUR;
            ctrl_c.alu_ctrl  = ALU_ADD;
            ctrl_c.pc_src    = PCSRC_ALU;
            ctrl_c.pc_write  = 1'b1;
            state_d          = STATE_DECODE;
         end
         STATE_DECODE: begin
            ctrl_c.alu_src_a = ALUA_PC;
            ctrl_c.alu_src_b = ALUB_IMM_SH2;
            ctrl_c.ext_op    = 1'b1;
            ctrl_c.alu_ctrl  = ALU_ADD;
            if (illegal) begin
               ctrl_c.illegal_instr = 1'b1;
            end else if (cls[CLS_J]) begin
               ctrl_c.pc_write = 1'b1;
               ctrl_c.pc_src   = PCSRC_JUMP;
               retire          = 1'b1;
            end else begin
               state_d = STATE_EXECUTE;
            end
         end
         STATE_EXECUTE: begin
            if (is_r_arith) begin
               ctrl_c.alu_src_a = ALUA_A;
               ctrl_c.alu_src_b = ALUB_B;
               ctrl_c.alu_ctrl  = r_alu_ctrl(cls);
               state_d          = STATE_WRITEBACK;
            end else if (cls[CLS_ORI]) begin
               ctrl_c.alu_src_a = ALUA_A;
               ctrl_c.alu_src_b = ALUB_IMM;
               ctrl_c.alu_ctrl  = ALU_OR;
               state_d          = STATE_WRITEBACK;
            end else if (cls[CLS_LUI]) begin
               ctrl_c.alu_src_b = ALUB_IMM;
               ctrl_c.alu_ctrl  = ALU_LUI;
               state_d          = STATE_WRITEBACK;
            end else if (cls[CLS_LW] | cls[CLS_SW]) begin
               ctrl_c.alu_src_a = ALUA_A;
               ctrl_c.alu_src_b = ALUB_IMM;
               ctrl_c.ext_op    = 1'b1;
               ctrl_c.alu_ctrl  = ALU_ADD;
               state_d          = STATE_MEMORY;
            end else if (cls[CLS_BEQ]) begin
               ctrl_c.alu_src_a     = ALUA_A;
               ctrl_c.alu_src_b     = ALUB_B;
               ctrl_c.alu_ctrl      = ALU_SUB;
               ctrl_c.pc_write_cond = 1'b1;
               ctrl_c.pc_src        = PCSRC_ALUOUT;
               retire               = 1'b1;
            end else if (cls[CLS_JR]) begin
               ctrl_c.pc_write = 1'b1;
               ctrl_c.pc_src   = PCSRC_REG;
               retire          = 1'b1;
            end else if (cls[CLS_JAL]) begin
               ctrl_c.reg_write  = 1'b1;
               ctrl_c.reg_dst    = REGDST_RA;
               ctrl_c.mem_to_reg = MEMTOREG_LINK;
               ctrl_c.pc_write   = 1'b1;
               ctrl_c.pc_src     = PCSRC_JUMP;
               retire            = 1'b1;
            end
         end
         STATE_MEMORY: begin
            if (cls[CLS_LW]) begin
               ctrl_c.mem_read = 1'b1;
               state_d         = STATE_WRITEBACK;
            end else if (cls[CLS_SW]) begin
               ctrl_c.mem_write = 1'b1;
               retire           = 1'b1;
            end
         end
         STATE_WRITEBACK: begin
            ctrl_c.reg_write = 1'b1;
            if (is_r_arith) begin
               ctrl_c.reg_dst    = REGDST_RD;
               ctrl_c.mem_to_reg = MEMTOREG_ALUOUT;
            end else if (cls[CLS_LW]) begin
               ctrl_c.reg_dst    = REGDST_RT;
               ctrl_c.mem_to_reg = MEMTOREG_MDR;
            end else begin
               ctrl_c.reg_dst    = REGDST_RT;
               ctrl_c.mem_to_reg = MEMTOREG_ALUOUT;
            end
            retire = 1'b1;
         end
         default: begin
            ctrl_c  = '0;
            state_d = STATE_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= STATE_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (retire) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Reset must silence every enable even though the state already reads FETCH.
   assign ctrl = rst ? ctrl_c : '0;

   assign alu_ctrl      = ctrl.alu_ctrl;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign reg_write     = ctrl.reg_write;
   assign reg_dst       = ctrl.reg_dst;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign pc_src        = ctrl.pc_src;
   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign ir_write      = ctrl.ir_write;
   assign ext_op        = ctrl.ext_op;
   assign illegal_instr = ctrl.illegal_instr;
   assign current_state = state_q;
   assign instr_count   = cnt_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control unit for the MIPS-Lite3 datapath; drives every mux select and write enable of the multicycle core.
- It consumes the latched instruction register and ALU zero flag.
- It sequences each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, skipping states each opcode does not need.
- It also reports the current state, an illegal-instruction pulse and a retired-instruction count.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
instr  in  32  instruction register contents
zero  in  1  ALU zero flag
alu_ctrl  out  3  ALU op: ADD=000 SUB=001 OR=010 SLT=011 LUI=100 (b<<16)
alu_src_a  out  2  00 PC, 01 A
alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
mem_read  out  1  data memory read
mem_write  out  1  data memory write
reg_write  out  1  register file write
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 link value
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A
pc_write  out  1  unconditional PC write
pc_write_cond  out  1  PC write if zero
ir_write  out  1  IR load
ext_op  out  1  1 sign-extend, 0 zero-extend
current_state  out  3  FETCH=0 DECODE=1 EXECUTE=2 MEMORY=3 WRITEBACK=4
illegal_instr  out  1  one-cycle pulse on unsupported opcode/funct
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0, async):
  - State is forced to FETCH and instr_count to 0.
  - While rst=0, every output except current_state is forced to 0.
- Outputs are Moore-style: a combinational function of state and instr (opcode [31:26], funct [5:0]). Unlisted outputs are 0.
- Next state is registered on the rising clk edge.
- Supported instructions:
  - R-type (op 000000): addu 100001, subu 100011, slt 101010, jr 001000.
  - I-type/jump: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- FETCH:
  - ir_write=1, alu_src_a=00, alu_src_b=01, alu_ctrl=ADD, pc_src=00, pc_write=1.
  - Always goes to DECODE.
- DECODE:
  - alu_src_a=00, alu_src_b=11, ext_op=1, alu_ctrl=ADD (branch target into ALUOut).
  - j: also asserts pc_write=1, pc_src=10, then goes to FETCH (retires).
  - Illegal opcode or funct: illegal_instr=1, then goes to FETCH; the instruction does not retire.
  - All other instructions go to EXECUTE.
- EXECUTE:
  - R arithmetic: alu_src_a=01, alu_src_b=00, alu_ctrl from funct; goes to WRITEBACK.
  - ori: alu_src_a=01, alu_src_b=10, ext_op=0, OR; goes to WRITEBACK.
  - lui: alu_src_b=10, ext_op=0, LUI; goes to WRITEBACK.
  - lw/sw: alu_src_a=01, alu_src_b=10, ext_op=1, ADD; goes to MEMORY.
  - beq: alu_src_a=01, alu_src_b=00, SUB, pc_write_cond=1, pc_src=01; goes to FETCH.
  - jr: pc_write=1, pc_src=11; goes to FETCH.
  - jal: reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_src=10; goes to FETCH.
- MEMORY:
  - lw: mem_read=1; goes to WRITEBACK.
  - sw: mem_write=1; goes to FETCH.
- WRITEBACK:
  - reg_write=1 in all cases; goes to FETCH.
  - R-type: reg_dst=01, mem_to_reg=00.
  - ori/lui: reg_dst=00, mem_to_reg=00.
  - lw: reg_dst=00, mem_to_reg=01.
- Cycle counts per instruction:
  - j: 2.
  - beq, jr, jal: 3.
  - sw: 4.
  - R-type, ori, lui: 4.
  - lw: 5.
- Retirement:
  - instr_count increments on every transition into FETCH from a legal instruction, including a not-taken beq.
  - Wraps modulo 2^CNT_W.
- instr is assumed stable outside FETCH, since IR is written only in FETCH.
- Unreachable state encodings (5-7) recover to FETCH on the next clock with all outputs 0.
- Reset asserted mid-instruction aborts it: no writes, and the count is not incremented.
- Exactly one of pc_write, pc_write_cond, or neither is asserted in any cycle. mem_read and mem_write are never both 1.

Decomposition:
- Shared package/header (extends definitions.vh): STATE_* encodings, OP_* opcodes, FUNCT_* codes, ALU_* control codes, and the mux-select constants for alu_src_a/b, reg_dst, mem_to_reg and pc_src.
- One sub-module, mc_instr_decode: purely combinational. Maps instr to a one-hot instruction class plus an illegal flag. The FSM consumes only the class.

Test Plan:
- Reset: hold rst=0 for 3 cycles with instr=0x3C011234 → all enables 0, current_state=0, instr_count=0. After release, the first cycle has ir_write=1, pc_write=1, alu_src_b=01.
- addu $3,$1,$2 (0x00221821) → states 0,1,2,4,0. In EXECUTE, alu_ctrl=000, alu_src_a=01. In WRITEBACK, reg_write=1, reg_dst=01. instr_count +1.
- lw $2,8($1) (0x8C220008) → states 0,1,2,3,4,0. In MEMORY, mem_read=1. In WRITEBACK, mem_to_reg=01, reg_dst=00. sw (0xAC220008) → mem_write=1 in MEMORY, then FETCH after 4 cycles.
- beq (0x10220003):
  - zero=1 → in EXECUTE pc_write_cond=1, pc_src=01, alu_ctrl=001; 3 cycles.
  - zero=0 → same outputs, instr_count still +1.
- j (0x08000010) → 2 cycles, pc_src=10 with pc_write=1 in DECODE. jal (0x0C000010) → in EXECUTE reg_dst=10, mem_to_reg=10, reg_write=1.
- Illegal op 0xFC000000 → illegal_instr pulses 1 cycle in DECODE, returns to FETCH, instr_count unchanged. Set instr_count to all-ones via repeated instructions → next retire wraps to 0.
